// File: rtl/oven_heat_controller.sv
// rtl/oven_heat_controller.sv - oven preheat/cook sequencer with temperature model; OVEN_COOLDOWN_EN adds a COOLDOWN phase
module oven_heat_controller #(
  parameter int TICK_COUNT = 50000000,
  parameter int MIN_TEMP   = 65,
  parameter int MAX_TEMP   = 500,
  parameter int RAMP_STEP  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
  input  logic [9:0]  target_temp,
  input  logic [12:0] target_time,
  output logic [9:0]  current_temp,
  output logic [12:0] time_left,
  output logic        heater_on,
  output logic [2:0]  state,
  output logic        busy,
  output logic        done
);

  localparam int            PW         = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_COUNT - 1);
  localparam logic [9:0]    MIN_T      = 10'(MIN_TEMP);
  localparam logic [9:0]    MAX_T      = 10'(MAX_TEMP);
  localparam logic [9:0]    STEP       = 10'(RAMP_STEP);

  // COOLDOWN only exists as an encoding when the cooldown phase is built in
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREHEAT  = 3'd1,
    S_COOK     = 3'd2,
`ifdef OVEN_COOLDOWN_EN
    S_COOLDOWN = 3'd3,
`endif
    S_DONE     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    temp_q, temp_d;
  logic [9:0]    tgt_q, tgt_d;
  logic [12:0]   time_q, time_d;
  logic [9:0]    tgt_clamped;
  logic [9:0]    rise_diff, fall_diff, cool_diff;
  logic          tick;

  // The tick fires on the cycle whose edge wraps the prescaler back to 0
  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  assign tgt_clamped = (target_temp < MIN_T) ? MIN_T :
                       (target_temp > MAX_T) ? MAX_T : target_temp;

  // Sequencing: cancel wins over everything, start is honoured only from IDLE or DONE
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tgt_d   = tgt_q;
    if (cancel) begin
      state_d = S_IDLE;
      time_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_PREHEAT;
            tgt_d   = tgt_clamped;
            time_d  = target_time;
          end
        end
        S_PREHEAT: begin
          if (temp_q == tgt_q) state_d = S_COOK;
        end
        S_COOK: begin
          if (time_q == '0) begin
`ifdef OVEN_COOLDOWN_EN
            state_d = S_COOLDOWN;
`else
            state_d = S_DONE;
`endif
          end else if (tick) begin
            time_d = time_q - 13'd1;
          end
        end
`ifdef OVEN_COOLDOWN_EN
        S_COOLDOWN: begin
          if (temp_q == MIN_T) state_d = S_DONE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Temperature model: ramp toward target in PREHEAT, hold in COOK, otherwise cool toward ambient
  always_comb begin
    rise_diff = tgt_q - temp_q;
    fall_diff = temp_q - tgt_q;
    cool_diff = temp_q - MIN_T;
    temp_d    = temp_q;
    if (tick) begin
      if (!cancel && state_q == S_PREHEAT) begin
        if (temp_q < tgt_q) begin
          temp_d = temp_q + ((rise_diff < STEP) ? rise_diff : STEP);
        end else begin
          temp_d = temp_q - ((fall_diff < STEP) ? fall_diff : STEP);
        end
      end else if (!cancel && state_q == S_COOK) begin
        temp_d = temp_q;
      end else if (temp_q > MIN_T) begin
        temp_d = temp_q - ((cool_diff < STEP) ? cool_diff : STEP);
      end
    end
  end

  // State and datapath registers, reset to an idle oven at ambient
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      temp_q  <= MIN_T;
      tgt_q   <= MIN_T;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      temp_q  <= temp_d;
      tgt_q   <= tgt_d;
      time_q  <= time_d;
    end
  end

  assign state        = state_q;
  assign current_temp = temp_q;
  assign time_left    = time_q;
  assign done         = (state_q == S_DONE);
  assign heater_on    = (state_q == S_COOK) || ((state_q == S_PREHEAT) && (temp_q < tgt_q));
`ifdef OVEN_COOLDOWN_EN
  assign busy = (state_q == S_PREHEAT) || (state_q == S_COOK) || (state_q == S_COOLDOWN);
`else
  assign busy = (state_q == S_PREHEAT) || (state_q == S_COOK);
`endif

endmodule

// File: tb/tb_oven_heat_controller.sv
// tb/tb_oven_heat_controller.sv - self-checking bench for oven_heat_controller (TICK_COUNT=4)
module tb_oven_heat_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [9:0]  target_temp = '0;
  logic [12:0] target_time = '0;
  logic [9:0]  current_temp;
  logic [12:0] time_left;
  logic        heater_on;
  logic [2:0]  state;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  oven_heat_controller #(
    .TICK_COUNT(4), .MIN_TEMP(65), .MAX_TEMP(500), .RAMP_STEP(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel),
    .target_temp(target_temp), .target_time(target_time),
    .current_temp(current_temp), .time_left(time_left), .heater_on(heater_on),
    .state(state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t_temp;
    int t_time;
    int exp_temp;
    int exp_steps;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    cancel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int tt, input int tm, input bit with_cancel);
    target_temp = 10'(tt);
    target_time = 13'(tm);
    start = 1'b1;
    cancel = with_cancel;
    @(negedge clk);
    start = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic wait_state(input int s, input int bound, input string name);
    int c = 0;
    while (state != 3'(s) && c < bound) begin
      @(negedge clk);
      c++;
    end
    check(name, state, s);
  endtask

  task automatic run_vector(input vec_t v);
    int prev_t, prev_tl, ph, steps, cook, first_tl, dec, bad_dec, heat_err, busy_err, cook_temp, cd;
    do_reset();
    pulse_start(v.t_temp, v.t_time, 1'b0);
    prev_t = 65; prev_tl = -1; ph = 0; steps = 0; cook = 0; first_tl = -1; dec = 0;
    bad_dec = 0; heat_err = 0; busy_err = 0; cook_temp = -1; cd = 0;
    for (int c = 0; c < 3000 && state != 3'd4; c++) begin
      case (state)
        3'd1: begin
          ph++;
          if (current_temp != 10'(prev_t)) steps++;
          if (heater_on != (int'(current_temp) < v.exp_temp)) heat_err++;
          if (!busy) busy_err++;
        end
        3'd2: begin
          if (cook == 0) begin
            first_tl  = time_left;
            cook_temp = current_temp;
          end else if (int'(time_left) != prev_tl) begin
            dec++;
            if (prev_tl - int'(time_left) != 1) bad_dec++;
          end
          if (int'(current_temp) != v.exp_temp) heat_err++;
          if (!heater_on) heat_err++;
          if (!busy) busy_err++;
          cook++;
        end
        3'd3: begin
          cd++;
          if (heater_on) heat_err++;
          if (!busy) busy_err++;
        end
        default: ;
      endcase
      prev_t  = current_temp;
      prev_tl = time_left;
      @(negedge clk);
    end
    check($sformatf("v%0d_reach_done", v.t_temp), state, 4);
    check($sformatf("v%0d_preheat_steps", v.t_temp), steps, v.exp_steps);
    check($sformatf("v%0d_cook_temp", v.t_temp), cook_temp, v.exp_temp);
    check($sformatf("v%0d_first_time_left", v.t_temp), first_tl, v.t_time);
    check($sformatf("v%0d_decrements", v.t_temp), dec, v.t_time);
    check($sformatf("v%0d_bad_decrements", v.t_temp), bad_dec, 0);
    check($sformatf("v%0d_heater_errors", v.t_temp), heat_err, 0);
    check($sformatf("v%0d_busy_errors", v.t_temp), busy_err, 0);
    check($sformatf("v%0d_done_flag", v.t_temp), done, 1);
    check($sformatf("v%0d_done_heater", v.t_temp), heater_on, 0);
    check($sformatf("v%0d_done_busy", v.t_temp), busy, 0);
    if (v.exp_steps == 0) check($sformatf("v%0d_preheat_cycles", v.t_temp), ph, 1);
    if (v.t_time == 0) check($sformatf("v%0d_cook_cycles", v.t_temp), cook, 1);
`ifdef OVEN_COOLDOWN_EN
    check($sformatf("v%0d_done_temp", v.t_temp), current_temp, 65);
`else
    check($sformatf("v%0d_no_cooldown", v.t_temp), cd, 0);
`endif
  endtask

  initial begin
    int c;
    int steps;
    int prev_t;
    int busy_err;

    vecs[0] = '{100,  3, 100,  7};
    vecs[1] = '{600,  2, 500, 87};
    vecs[2] = '{20,   0,  65,  0};
    vecs[3] = '{67,   1,  67,  1};
    vecs[4] = '{1023, 0, 500, 87};
    vecs[5] = '{65,   2,  65,  0};

    // reset state
    do_reset();
    check("rst_state", state, 0);
    check("rst_temp", current_temp, 65);
    check("rst_time_left", time_left, 0);
    check("rst_heater", heater_on, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    foreach (vecs[i]) run_vector(vecs[i]);

    // start ignored while busy
    do_reset();
    pulse_start(100, 3, 1'b0);
    repeat (6) @(negedge clk);
    pulse_start(300, 9, 1'b0);
    wait_state(2, 200, "busy_start_reach_cook");
    check("busy_start_temp", current_temp, 100);
    check("busy_start_time_left", time_left, 3);

    // cancel during COOK with time_left 5
    do_reset();
    pulse_start(70, 5, 1'b0);
    wait_state(2, 100, "cancel_reach_cook");
    check("cancel_pre_time_left", time_left, 5);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_state", state, 0);
    check("cancel_time_left", time_left, 0);
    check("cancel_heater", heater_on, 0);
    check("cancel_busy", busy, 0);
    repeat (8) @(negedge clk);
    check("cancel_cooled", current_temp, 65);

    // start and cancel together in IDLE
    do_reset();
    pulse_start(100, 9, 1'b1);
    check("start_cancel_state", state, 0);
    check("start_cancel_time_left", time_left, 0);
    repeat (12) @(negedge clk);
    check("start_cancel_temp", current_temp, 65);

    // DONE hold, background cooling, restart from DONE, cancel from DONE
    do_reset();
    pulse_start(100, 0, 1'b0);
    wait_state(4, 800, "hold_reach_done");
    repeat (40) @(negedge clk);
    check("hold_still_done", state, 4);
    check("hold_cooled", current_temp, 65);
    pulse_start(70, 0, 1'b0);
    check("restart_from_done", state, 1);
    wait_state(4, 400, "restart_reach_done");
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_from_done", state, 0);
    check("cancel_from_done_flag", done, 0);

`ifdef OVEN_COOLDOWN_EN
    // cooldown phase: 100 -> 65 in 7 ticks, busy throughout
    do_reset();
    pulse_start(100, 1, 1'b0);
    wait_state(3, 400, "cd_reach_cooldown");
    steps = 0;
    busy_err = 0;
    prev_t = current_temp;
    c = 0;
    while (state == 3'd3 && c < 400) begin
      if (int'(current_temp) != prev_t) steps++;
      if (!busy) busy_err++;
      prev_t = current_temp;
      @(negedge clk);
      c++;
    end
    check("cd_steps", steps, 7);
    check("cd_busy_errors", busy_err, 0);
    check("cd_state_done", state, 4);
    check("cd_temp", current_temp, 65);
    check("cd_busy_after", busy, 0);
`endif

    // asynchronous reset mid-cycle during PREHEAT at 85
    do_reset();
    pulse_start(100, 3, 1'b0);
    c = 0;
    while (!(state == 3'd1 && current_temp == 10'd85) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("arst_reach_85", current_temp, 85);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_temp", current_temp, 65);
    check("arst_time_left", time_left, 0);
    check("arst_heater", heater_on, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle_after", state, 0);
    pulse_start(70, 1, 1'b0);
    check("arst_resume", state, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oven_heat_controller.md
OVEN_HEAT_CONTROLLER -- requirements
Module: oven_heat_controller

Interface
REQ-001 SHALL have parameter TICK_COUNT, default 50000000: clk cycles per 1 s tick.
REQ-002 SHALL have parameter MIN_TEMP, default 65: ambient temperature and lower clamp.
REQ-003 SHALL have parameter MAX_TEMP, default 500: upper clamp.
REQ-004 SHALL have parameter RAMP_STEP, default 5: degrees moved per tick.
REQ-005 SHALL have port clk  input  1: single clock; all state changes on posedge clk.
REQ-006 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1: one-cycle request to begin a cook cycle.
REQ-008 SHALL have port cancel  input  1: abort request.
REQ-009 SHALL have port target_temp  input  10: requested temperature in degrees.
REQ-010 SHALL have port target_time  input  13: requested cook time in seconds.
REQ-011 SHALL have port current_temp  output  10: modelled oven temperature.
REQ-012 SHALL have port time_left  output  13: remaining cook seconds.
REQ-013 SHALL have port heater_on  output  1: heater drive.
REQ-014 SHALL have port state  output  3: IDLE=0, PREHEAT=1, COOK=2, COOLDOWN=3, DONE=4.
REQ-015 SHALL have port busy  output  1: high in PREHEAT, COOK and COOLDOWN.
REQ-016 SHALL have port done  output  1: high while in DONE.

Function
REQ-017 SHALL run a free-running prescaler 0..TICK_COUNT-1, giving a one-cycle tick when the count wraps to 0.
REQ-018 SHALL accept start only in IDLE or DONE: latch clamp(target_temp, MIN_TEMP, MAX_TEMP) and target_time into time_left; go to PREHEAT next cycle.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL, in PREHEAT on each tick, move current_temp toward the latched target by min(RAMP_STEP, |difference|).
REQ-021 SHALL leave PREHEAT for COOK on the first cycle current_temp equals the latched target, including immediately when they are equal at entry.
REQ-022 SHALL, in COOK on each tick, hold current_temp and decrement time_left.
REQ-023 SHALL leave COOK on the cycle time_left is 0; when target_time is 0, COOK lasts one cycle.
REQ-024 SHALL drive heater_on = 1 in COOK, and in PREHEAT only while current_temp < target; 0 elsewhere.
REQ-025 SHALL, outside PREHEAT and COOK on each tick, decrease current_temp by min(RAMP_STEP, current_temp - MIN_TEMP), never going below MIN_TEMP.
REQ-026 SHALL keep time_left, current_temp and all arithmetic non-wrapping: no underflow below 0 or MIN_TEMP, no overflow above MAX_TEMP.
REQ-027 SHALL, on cancel in any state, go to IDLE next cycle with time_left = 0 and heater_on = 0; current_temp then cools per REQ-025.
REQ-028 SHALL give cancel priority over start in the same cycle.
REQ-029 SHALL hold DONE until start (new cycle) or cancel (to IDLE).

Reset
REQ-030 SHALL, while rst is high, asynchronously force: state = IDLE, current_temp = MIN_TEMP, time_left = 0, heater_on = 0, busy = 0, done = 0, prescaler = 0, latched target = MIN_TEMP.
REQ-031 SHALL, when rst is asserted mid-cycle in any state, abandon that cycle and resume from IDLE on the first clk edge after release.

Configuration
REQ-032 SHALL provide the feature macro OVEN_COOLDOWN_EN.
REQ-033 SHALL, when OVEN_COOLDOWN_EN is defined, go from COOK to COOLDOWN, cool per REQ-025, and enter DONE on the cycle current_temp equals MIN_TEMP.
REQ-034 SHALL, when OVEN_COOLDOWN_EN is undefined, go from COOK directly to DONE, never encode COOLDOWN, and let current_temp cool in the background in DONE and IDLE.

Verification (TICK_COUNT=4, RAMP_STEP=5, macro undefined unless stated)
REQ-035 SHALL test: start with target 100, time 3 -> PREHEAT for 7 ticks (65->100), COOK with time_left 3,2,1,0, then DONE with done = 1 and heater_on = 0.
REQ-036 SHALL test: start with target 600 -> latched 500; start with target 20 -> latched 65 and PREHEAT->COOK in one cycle.
REQ-037 SHALL test: cancel during COOK with time_left 5 -> next cycle IDLE, time_left = 0, heater_on = 0, busy = 0.
REQ-038 SHALL test: start and cancel in the same cycle while in IDLE -> stays IDLE, time_left unchanged at 0.
REQ-039 SHALL test: with OVEN_COOLDOWN_EN, target 100, time 1 -> COOLDOWN for 7 ticks to 65, then DONE; busy high until DONE.
REQ-040 SHALL test: assert rst between clk edges during PREHEAT at 85 -> outputs immediately at reset values (state 0, current_temp 65).
